// File: rtl/k_alu_if.sv
// k_alu_if: groups the execute-stage datapath signals of k_alu.
//   master : drives controls/operands, observes results (testbench, decode stage)
//   slave  : the k_alu datapath itself
// Inputs : alu_src, reg_dst, mem_to_reg, alu_control[3:0], read_data1/2[31:0],
//          imm_ext[31:0], rt/rd[4:0], mem_read_data[31:0]
// Outputs: alu_result[31:0], zero, write_reg[4:0], alu_result_q[31:0], zero_q,
//          write_reg_q[4:0], store_data_q[31:0], write_back[31:0]
interface k_alu_if;
  logic        alu_src;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [3:0]  alu_control;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm_ext;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] mem_read_data;

  logic [31:0] alu_result;
  logic        zero;
  logic [4:0]  write_reg;
  logic [31:0] alu_result_q;
  logic        zero_q;
  logic [4:0]  write_reg_q;
  logic [31:0] store_data_q;
  logic [31:0] write_back;

  modport master (
    output alu_src, reg_dst, mem_to_reg, alu_control, read_data1, read_data2,
           imm_ext, rt, rd, mem_read_data,
    input  alu_result, zero, write_reg, alu_result_q, zero_q, write_reg_q,
           store_data_q, write_back
  );

  modport slave (
    input  alu_src, reg_dst, mem_to_reg, alu_control, read_data1, read_data2,
           imm_ext, rt, rd, mem_read_data,
    output alu_result, zero, write_reg, alu_result_q, zero_q, write_reg_q,
           store_data_q, write_back
  );
endinterface

// File: rtl/k_alu.sv
// k_alu: execute-stage slice of the single-cycle MIPS core.
// Operand-B mux, destination mux, 32-bit ALU with zero flag, a one-cycle
// registered copy of the results, and the write-back mux.
// Ports:
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset for the registered outputs
//   bus     : k_alu_if.slave carrying operands, controls and results
module k_alu (
  input logic    clock,
  input logic    reset_n,
  k_alu_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic        result_zero;
  logic [4:0]  dest;

  logic [31:0] result_q;
  logic        zero_flag_q;
  logic [4:0]  dest_q;
  logic [31:0] store_q;

  assign op_a = bus.read_data1;
  assign op_b = bus.alu_src ? bus.imm_ext : bus.read_data2;
  assign dest = bus.reg_dst ? bus.rd : bus.rt;

  always_comb begin
    result = 32'd0;
    unique case (bus.alu_control)
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_ADD:  result = op_a + op_b;
      OP_SUB:  result = op_a - op_b;
      OP_SLT:  result = {31'd0, ($signed(op_a) < $signed(op_b))};
      OP_NOR:  result = ~(op_a | op_b);
      default: result = 32'd0;  // undefined codes read as zero so zero=1
    endcase
  end

  // zero follows the decoded result, including the undefined-code case
  assign result_zero = (result == 32'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      result_q    <= 32'd0;
      zero_flag_q <= 1'b1;  // matches the cleared result
      dest_q      <= 5'd0;
      store_q     <= 32'd0;
    end else begin
      result_q    <= result;
      zero_flag_q <= result_zero;
      dest_q      <= dest;
      store_q     <= bus.read_data2;
    end
  end

  assign bus.alu_result   = result;
  assign bus.zero         = result_zero;
  assign bus.write_reg    = dest;
  assign bus.alu_result_q = result_q;
  assign bus.zero_q       = zero_flag_q;
  assign bus.write_reg_q  = dest_q;
  assign bus.store_data_q = store_q;
  // registered ALU result (previous cycle) vs. live memory data
  assign bus.write_back   = bus.mem_to_reg ? bus.mem_read_data : result_q;

endmodule

// File: tb/tb_k_alu.sv
module tb_k_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic [4:0]  wr;
    logic [31:0] sd;
  } exp_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  k_alu_if bus ();

  k_alu u_dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] ctrl, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic dst,
                       input logic [4:0] t, input logic [4:0] d);
    bus.alu_control = ctrl;
    bus.alu_src     = src;
    bus.read_data1  = a;
    bus.read_data2  = b;
    bus.imm_ext     = imm;
    bus.reg_dst     = dst;
    bus.rt          = t;
    bus.rd          = d;
  endtask

  task automatic edge_sample();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(4'b0010, 1'b0, 32'h0000_0100, 32'h0000_0023, 32'h0, 1'b1, 5'd3, 5'd9);
    edge_sample();
    edge_sample();
    checks++; if (bus.alu_result_q !== 32'd0) begin failures++;
      $display("FAIL reset_alu_q: got %h expected %h", bus.alu_result_q, 32'd0); end
    checks++; if (bus.zero_q !== 1'b1) begin failures++;
      $display("FAIL reset_zero_q: got %b expected 1", bus.zero_q); end
    checks++; if (bus.write_reg_q !== 5'd0) begin failures++;
      $display("FAIL reset_write_reg_q: got %0d expected 0", bus.write_reg_q); end
    checks++; if (bus.store_data_q !== 32'd0) begin failures++;
      $display("FAIL reset_store_q: got %h expected 0", bus.store_data_q); end
    checks++; if (bus.alu_result !== 32'h0000_0123) begin failures++;
      $display("FAIL reset_comb_alu: got %h expected 00000123", bus.alu_result); end
    reset_n = 1'b1;
  endtask

  task automatic test_add_wrap();
    exp_t e;
    drive(4'b0010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h7, 1'b0, 5'd3, 5'd4);
    #1;
    checks++; if (bus.alu_result !== 32'd0) begin failures++;
      $display("FAIL add_wrap_result: got %h expected 0", bus.alu_result); end
    checks++; if (bus.zero !== 1'b1) begin failures++;
      $display("FAIL add_wrap_zero: got %b expected 1", bus.zero); end
    sb.push_back('{res: 32'd0, z: 1'b1, wr: 5'd3, sd: 32'h1});
    edge_sample();
    e = sb.pop_front();
    checks++; if (bus.alu_result_q !== e.res) begin failures++;
      $display("FAIL add_wrap_alu_q: got %h expected %h", bus.alu_result_q, e.res); end
    checks++; if (bus.zero_q !== e.z) begin failures++;
      $display("FAIL add_wrap_zero_q: got %b expected %b", bus.zero_q, e.z); end
    checks++; if (bus.write_reg_q !== e.wr) begin failures++;
      $display("FAIL add_wrap_wr_q: got %0d expected %0d", bus.write_reg_q, e.wr); end
    checks++; if (bus.store_data_q !== e.sd) begin failures++;
      $display("FAIL add_wrap_store_q: got %h expected %h", bus.store_data_q, e.sd); end
  endtask

  task automatic test_imm();
    drive(4'b0010, 1'b1, 32'd10, 32'h0000_0999, 32'hFFFF_FFFB, 1'b0, 5'd1, 5'd2);
    #1;
    checks++; if (bus.alu_result !== 32'd5) begin failures++;
      $display("FAIL imm_add: got %h expected 5", bus.alu_result); end
    bus.alu_control = 4'b0110;
    #1;
    checks++; if (bus.alu_result !== 32'd15) begin failures++;
      $display("FAIL imm_sub: got %h expected f", bus.alu_result); end
    checks++; if (bus.zero !== 1'b0) begin failures++;
      $display("FAIL imm_sub_zero: got %b expected 0", bus.zero); end
  endtask

  task automatic test_slt();
    drive(4'b0111, 1'b0, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 5'd0, 5'd0);
    #1;
    checks++; if (bus.alu_result !== 32'd1) begin failures++;
      $display("FAIL slt_neg_lt_pos: got %h expected 1", bus.alu_result); end
    drive(4'b0111, 1'b0, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 5'd0, 5'd0);
    #1;
    checks++; if (bus.alu_result !== 32'd0) begin failures++;
      $display("FAIL slt_pos_lt_neg: got %h expected 0", bus.alu_result); end
  endtask

  task automatic test_logic();
    logic [3:0]  ctrls [4] = '{4'b0000, 4'b0001, 4'b1100, 4'b1010};
    logic [31:0] wants [4] = '{32'h000F_000F, 32'h0FFF_0FFF, 32'hF000_F000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(ctrls[i], 1'b0, 32'h0F0F_00FF, 32'h00FF_0F0F, 32'h0, 1'b0, 5'd0, 5'd0);
      #1;
      checks++; if (bus.alu_result !== wants[i]) begin failures++;
        $display("FAIL logic_op_%b: got %h expected %h", ctrls[i], bus.alu_result, wants[i]); end
    end
    checks++; if (bus.zero !== 1'b1) begin failures++;
      $display("FAIL logic_undef_zero: got %b expected 1", bus.zero); end
  endtask

  task automatic test_mux();
    drive(4'b0010, 1'b0, 32'h1, 32'h1, 32'h0, 1'b0, 5'd8, 5'd17);
    #1;
    checks++; if (bus.write_reg !== 5'd8) begin failures++;
      $display("FAIL mux_rt: got %0d expected 8", bus.write_reg); end
    bus.reg_dst = 1'b1;
    #1;
    checks++; if (bus.write_reg !== 5'd17) begin failures++;
      $display("FAIL mux_rd: got %0d expected 17", bus.write_reg); end
  endtask

  task automatic test_reset_midstream();
    edge_sample();
    drive(4'b0010, 1'b1, 32'h0000_1234, 32'h55, 32'h0, 1'b1, 5'd8, 5'd17);
    edge_sample();
    checks++; if (bus.alu_result_q !== 32'h1234 || bus.write_reg_q !== 5'd17 ||
                  bus.store_data_q !== 32'h55) begin failures++;
      $display("FAIL mid_load: got %h/%0d/%h expected 00001234/17/00000055",
               bus.alu_result_q, bus.write_reg_q, bus.store_data_q); end
    // write-back uses the registered result, not the live one
    bus.read_data1    = 32'h0000_0F00;
    bus.mem_to_reg    = 1'b0;
    bus.mem_read_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.write_back !== 32'h1234) begin failures++;
      $display("FAIL wb_alu_q: got %h expected 00001234", bus.write_back); end
    bus.mem_to_reg = 1'b1;
    #1;
    checks++; if (bus.write_back !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL wb_mem: got %h expected deadbeef", bus.write_back); end
    bus.mem_to_reg = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.alu_result !== 32'h0F00) begin failures++;
      $display("FAIL mid_comb_in_reset: got %h expected 00000f00", bus.alu_result); end
    edge_sample();
    checks++; if (bus.alu_result_q !== 32'd0 || bus.zero_q !== 1'b1 ||
                  bus.write_reg_q !== 5'd0 || bus.store_data_q !== 32'd0) begin failures++;
      $display("FAIL mid_reset_clear: got %h/%b/%0d/%h expected 0/1/0/0",
               bus.alu_result_q, bus.zero_q, bus.write_reg_q, bus.store_data_q); end
    reset_n = 1'b1;
    edge_sample();
    checks++; if (bus.alu_result_q !== 32'h0F00 || bus.zero_q !== 1'b0 ||
                  bus.write_reg_q !== 5'd17 || bus.store_data_q !== 32'h55) begin failures++;
      $display("FAIL mid_release_load: got %h/%b/%0d/%h expected 00000f00/0/17/00000055",
               bus.alu_result_q, bus.zero_q, bus.write_reg_q, bus.store_data_q); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] last_res;
    logic [31:0] a, b, imm, bsel, want;
    logic [3:0]  ctrl;
    logic        src, dst;
    logic [4:0]  t, d;
    last_res = 32'h0F00;
    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      b    = (i % 5 == 0) ? a : $urandom;
      imm  = $urandom;
      ctrl = 4'($urandom_range(0, 15));
      src  = 1'($urandom_range(0, 1));
      dst  = 1'($urandom_range(0, 1));
      t    = 5'($urandom_range(0, 31));
      d    = 5'($urandom_range(0, 31));
      drive(ctrl, src, a, b, imm, dst, t, d);
      bus.mem_to_reg    = 1'($urandom_range(0, 1));
      bus.mem_read_data = $urandom;
      bsel = src ? imm : b;
      want = model_alu(ctrl, a, bsel);
      #1;
      checks++; if (bus.alu_result !== want) begin failures++;
        $display("FAIL b2b_result[%0d]: got %h expected %h", i, bus.alu_result, want); end
      checks++; if (bus.zero !== (want == 32'd0)) begin failures++;
        $display("FAIL b2b_zero[%0d]: got %b expected %b", i, bus.zero, (want == 32'd0)); end
      checks++; if (bus.write_reg !== (dst ? d : t)) begin failures++;
        $display("FAIL b2b_wr[%0d]: got %0d expected %0d", i, bus.write_reg, (dst ? d : t)); end
      checks++;
      if (bus.write_back !== (bus.mem_to_reg ? bus.mem_read_data : last_res)) begin failures++;
        $display("FAIL b2b_wb[%0d]: got %h expected %h", i, bus.write_back,
                 (bus.mem_to_reg ? bus.mem_read_data : last_res)); end
      sb.push_back('{res: want, z: (want == 32'd0), wr: (dst ? d : t), sd: b});
      edge_sample();
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL b2b_scoreboard[%0d]: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bus.alu_result_q !== e.res || bus.zero_q !== e.z ||
            bus.write_reg_q !== e.wr || bus.store_data_q !== e.sd) begin failures++;
          $display("FAIL b2b_regs[%0d]: got %h/%b/%0d/%h expected %h/%b/%0d/%h", i,
                   bus.alu_result_q, bus.zero_q, bus.write_reg_q, bus.store_data_q,
                   e.res, e.z, e.wr, e.sd); end
        last_res = e.res;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.mem_read_data = 32'd0;
    drive(4'b0000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    test_reset();
    test_add_wrap();
    test_imm();
    test_slt();
    test_logic();
    test_mux();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
